fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Fetch-stage initiator that drives the instruction memory read port. It sequences the PC, issues read requests, and assembles one- and two-word instructions (opcode + 16-bit immediate) into a registered IF/ID output. It sits between the PC-redirect logic (branch/stall from later stages) and the pipeline decode stage.

Parameters:
RESET_PC, 32, PC value loaded on reset (start of instruction area, 2^5).
ADDR_W, 32, PC / memory address width.
INSTR_W, 16, instruction word width.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold fetch state and outputs this cycle
branch_taken  in  1  redirect PC to branch_target
branch_target  in  ADDR_W  redirect address
imem_address  out  ADDR_W  memory address; combinational = PC
imem_CS  out  1  memory chip select
imem_read  out  1  memory read strobe
imem_write  out  1  memory write strobe; constant 0
imem_readData  in  INSTR_W  memory read data; valid in the same cycle as the address
instr_out  out  INSTR_W  registered instruction word
imm_out  out  INSTR_W  registered immediate; 0 for one-word instructions
pc_out  out  ADDR_W  address of instr_out's first word
valid_out  out  1  instr_out/imm_out/pc_out hold a new instruction

Behaviour:
- Reset (rst_n=0, asynchronous): PC=RESET_PC, state=FETCH, hold reg=0, instr_out=imm_out=pc_out=0, valid_out=0. imem_CS=imem_read=0 while rst_n=0.
- imem_CS = imem_read = rst_n & ~stall. imem_write = 0 always.
- Two-word instruction: imem_readData[15:14]==2'b11 (covers LDM 11010).
- FETCH state:
  - One-word word read: instr_out<=word, imm_out<=0, pc_out<=PC, valid_out<=1, PC<=PC+1.
  - Two-word word read: hold<=word, hold_pc<=PC, PC<=PC+1, valid_out<=0, go to FETCH_IMM.
- FETCH_IMM state: instr_out<=hold, imm_out<=word, pc_out<=hold_pc, valid_out<=1, PC<=PC+1, go to FETCH.
- Latency: one-word instruction is valid 1 cycle after its address is presented. A two-word instruction is valid 1 cycle after its immediate address is presented.
- Priority per cycle: reset > branch_taken > stall > normal.
- branch_taken: PC<=branch_target, state<=FETCH, valid_out<=0. Any held first word is discarded, even in FETCH_IMM and even with stall=1.
- stall (no branch): PC, state, hold and all outputs keep their values. valid_out keeps its value and is not re-pulsed; downstream also sees stall.
- PC arithmetic is modulo 2^ADDR_W: 0xFFFFFFFF+1 = 0. The full address is driven; the memory decodes the low 20 bits.
- Reset mid-FETCH_IMM: returns to FETCH at RESET_PC; the partial instruction is lost.

Optional Feature:
Macro FETCH_RESET_VECTOR_EN.
- Defined: after reset the unit enters VEC_HI then VEC_LO, reading mem[0] (PC[31:16]) then mem[1] (PC[15:0]). It then enters FETCH at that PC. valid_out=0 throughout. stall and branch apply as in normal fetch; branch aborts vector load.
- Not defined: PC=RESET_PC directly and the VEC states do not exist.

Decomposition:
- Package fetch_pkg:
  - state enum {FETCH, FETCH_IMM, VEC_HI, VEC_LO}
  - INSTR_W, ADDR_W, RESET_PC_DEFAULT
  - TWO_WORD_PREFIX = 2'b11
  - function is_two_word(word)
- One sub-module is natural: fetch_pc_reg (PC register with redirect/stall/increment mux). The FSM and output register stay in fetch_unit.

Test Plan:
1. Reset release, mem[32]=0xA120 (NOT R1) -> first cycle: imem_address=32, CS=read=1. Next edge: instr_out=0xA120, imm_out=0, pc_out=32, valid_out=1.
2. mem[32]=0xD020 (LDM R1), mem[33]=0x0005 -> cycle 1: valid_out=0, address 33. Cycle 2: instr_out=0xD020, imm_out=0x0005, pc_out=32, valid_out=1, address 34.
3. Stall 3 cycles during FETCH_IMM -> PC stays 33, CS=read=0, outputs frozen. After release, LDM completes as in scenario 2.
4. branch_taken=1 with target 0x40 while in FETCH_IMM, stall also 1 -> next: PC=0x40, valid_out=0, state FETCH. Held 0xD020 is never output.
5. branch_target=0xFFFFFFFF holding one-word 0x0000 -> pc_out=0xFFFFFFFF, valid_out=1, next address 0.
6. FETCH_RESET_VECTOR_EN with mem[0]=0x0000, mem[1]=0x0100 -> addresses 0,1 with valid_out=0. Third cycle: address 0x100 and normal fetch follows. Without the macro, address is 32 immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W          = 16;
  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned RESET_PC_DEFAULT = 32;

  // Opcode prefix that marks an instruction followed by a 16-bit immediate word.
  localparam logic [1:0] TWO_WORD_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    FETCH_IMM = 2'd1,
    VEC_HI    = 2'd2,
    VEC_LO    = 2'd3
  } fetch_state_e;

  // True when the word is the first half of a two-word instruction.
  function automatic logic is_two_word(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: 2] == TWO_WORD_PREFIX;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory read port between the fetch unit (master) and memory (slave).
interface fetch_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 16
);

  logic [ADDR_W-1:0]  imem_address;
  logic               imem_CS;
  logic               imem_read;
  logic               imem_write;
  logic [INSTR_W-1:0] imem_readData;

  modport master (
    output imem_address,
    output imem_CS,
    output imem_read,
    output imem_write,
    input  imem_readData
  );

  modport slave (
    input  imem_address,
    input  imem_CS,
    input  imem_read,
    input  imem_write,
    output imem_readData
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter: redirect beats stall, stall beats vector load / increment.
module fetch_pc_reg #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [ADDR_W-1:0] pc
);

  // PC update; wraps modulo 2^ADDR_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= branch_target;
    end else if (!stall) begin
      pc <= load ? load_pc : pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: drives imem, assembles one/two-word instructions into IF/ID regs.
// Optional macro FETCH_RESET_VECTOR_EN: load the start PC from mem[0]/mem[1] after reset.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = fetch_pkg::ADDR_W,
  parameter int unsigned       INSTR_W  = fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(fetch_pkg::RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  fetch_if.master            bus,
  output logic [INSTR_W-1:0] instr_out,
  output logic [INSTR_W-1:0] imm_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               valid_out
);

  import fetch_pkg::*;

  localparam logic [1:0] ST_FETCH     = 2'(FETCH);
  localparam logic [1:0] ST_FETCH_IMM = 2'(FETCH_IMM);
`ifdef FETCH_RESET_VECTOR_EN
  localparam logic [1:0] ST_VEC_HI    = 2'(VEC_HI);
  localparam logic [1:0] ST_VEC_LO    = 2'(VEC_LO);
  localparam logic [1:0] ST_RESET     = ST_VEC_HI;
  localparam logic [ADDR_W-1:0] PC_RESET_VAL = '0;
`else
  localparam logic [1:0] ST_RESET     = ST_FETCH;
  localparam logic [ADDR_W-1:0] PC_RESET_VAL = RESET_PC;
`endif

  logic [1:0]         state, state_n;
  logic [INSTR_W-1:0] hold, hold_n;
  logic [ADDR_W-1:0]  hold_pc, hold_pc_n;
  logic [INSTR_W-1:0] instr_n, imm_n;
  logic [ADDR_W-1:0]  pc_out_n;
  logic               valid_n;
  logic [ADDR_W-1:0]  pc;
  logic               vec_load;
  logic [ADDR_W-1:0]  vec_pc;
  logic [INSTR_W-1:0] word;

  assign word = bus.imem_readData;

  // Memory port: address follows PC, access suppressed in reset and stall
  assign bus.imem_address = pc;
  assign bus.imem_CS      = rst_n & ~stall;
  assign bus.imem_read    = rst_n & ~stall;
  assign bus.imem_write   = 1'b0;

`ifdef FETCH_RESET_VECTOR_EN
  assign vec_load = (state == ST_VEC_LO);
  assign vec_pc   = ADDR_W'({hold, word});
`else
  assign vec_load = 1'b0;
  assign vec_pc   = '0;
`endif

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (PC_RESET_VAL)
  ) u_pc (
    .clk           (clk),
    .rst_n         (rst_n),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .load          (vec_load),
    .load_pc       (vec_pc),
    .pc            (pc)
  );

  // FSM state, held first word and IF/ID output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RESET;
      hold      <= '0;
      hold_pc   <= '0;
      instr_out <= '0;
      imm_out   <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      hold_pc   <= hold_pc_n;
      instr_out <= instr_n;
      imm_out   <= imm_n;
      pc_out    <= pc_out_n;
      valid_out <= valid_n;
    end
  end

  // Next state and next register values; branch discards any held first word
  always_comb begin
    state_n   = state;
    hold_n    = hold;
    hold_pc_n = hold_pc;
    instr_n   = instr_out;
    imm_n     = imm_out;
    pc_out_n  = pc_out;
    valid_n   = valid_out;
    if (branch_taken) begin
      state_n = ST_FETCH;
      valid_n = 1'b0;
    end else if (!stall) begin
      case (state)
        ST_FETCH: begin
          if (is_two_word(word)) begin
            hold_n    = word;
            hold_pc_n = pc;
            valid_n   = 1'b0;
            state_n   = ST_FETCH_IMM;
          end else begin
            instr_n  = word;
            imm_n    = '0;
            pc_out_n = pc;
            valid_n  = 1'b1;
          end
        end
        ST_FETCH_IMM: begin
          instr_n  = hold;
          imm_n    = word;
          pc_out_n = hold_pc;
          valid_n  = 1'b1;
          state_n  = ST_FETCH;
        end
`ifdef FETCH_RESET_VECTOR_EN
        ST_VEC_HI: begin
          hold_n  = word;
          valid_n = 1'b0;
          state_n = ST_VEC_LO;
        end
        ST_VEC_LO: begin
          valid_n = 1'b0;
          state_n = ST_FETCH;
        end
`endif
        default: state_n = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random stall/branch traffic
// checked against an instruction-stream reference model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [15:0] instr_out;
  logic [15:0] imm_out;
  logic [31:0] pc_out;
  logic        valid_out;

  logic [15:0] mem [0:1023];

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_imm;
  logic [31:0] m_pcout;
  logic        m_valid;
  logic [47:0] held_q[$];
  int          vec_phase;
  logic [15:0] vec_hi;

  fetch_if #(.ADDR_W(32), .INSTR_W(16)) bus ();

  assign bus.imem_readData = mem[bus.imem_address[9:0]];

  fetch_unit #(.ADDR_W(32), .INSTR_W(16), .RESET_PC(32'd32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .bus           (bus),
    .instr_out     (instr_out),
    .imm_out       (imm_out),
    .pc_out        (pc_out),
    .valid_out     (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
`ifdef FETCH_RESET_VECTOR_EN
    m_pc      = 32'd0;
    vec_phase = 2;
`else
    m_pc      = 32'd32;
    vec_phase = 0;
`endif
    held_q.delete();
    m_instr = '0;
    m_imm   = '0;
    m_pcout = '0;
    m_valid = 1'b0;
  endtask

  task automatic check_outputs();
    chk("instr_out", 32'(instr_out), 32'(m_instr));
    chk("imm_out",   32'(imm_out),   32'(m_imm));
    chk("pc_out",    pc_out,         m_pcout);
    chk("valid_out", 32'(valid_out), 32'(m_valid));
  endtask

  // One clock: drive inputs, check the memory port, predict, check the IF/ID regs
  task automatic cycle(input logic st, input logic br, input logic [31:0] tgt);
    logic [15:0] word;
    logic [47:0] h;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    #1;
    chk("imem_address", bus.imem_address, m_pc);
    chk("imem_CS",      32'(bus.imem_CS),    32'(!st));
    chk("imem_read",    32'(bus.imem_read),  32'(!st));
    chk("imem_write",   32'(bus.imem_write), 32'd0);
    word = mem[m_pc[9:0]];
    if (br) begin
      m_pc      = tgt;
      held_q.delete();
      m_valid   = 1'b0;
      vec_phase = 0;
    end else if (!st) begin
      if (vec_phase == 2) begin
        vec_hi    = word;
        m_pc      = m_pc + 32'd1;
        vec_phase = 1;
        m_valid   = 1'b0;
      end else if (vec_phase == 1) begin
        m_pc      = {vec_hi, word};
        vec_phase = 0;
        m_valid   = 1'b0;
      end else if (held_q.size() > 0) begin
        h       = held_q.pop_front();
        m_pcout = h[47:16];
        m_instr = h[15:0];
        m_imm   = word;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd1;
      end else if (word[15:14] == 2'b11) begin
        held_q.push_back({m_pc, word});
        m_valid = 1'b0;
        m_pc    = m_pc + 32'd1;
      end else begin
        m_instr = word;
        m_imm   = 16'd0;
        m_pcout = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic check_in_reset();
    chk("rst_imem_CS",   32'(bus.imem_CS),   32'd0);
    chk("rst_imem_read", 32'(bus.imem_read), 32'd0);
    chk("rst_address",   bus.imem_address,   m_pc);
    check_outputs();
  endtask

  initial begin
    rst_n         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h1000;
    mem[0]    = 16'h0000;
    mem[1]    = 16'h0020;
    mem[32]   = 16'hA120;
    mem[33]   = 16'hD020;
    mem[34]   = 16'h0005;
    mem[35]   = 16'hD020;
    mem[36]   = 16'h0007;
    mem[37]   = 16'hD020;
    mem[38]   = 16'h0009;
    mem[64]   = 16'h2222;
    mem[1023] = 16'h0000;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_in_reset();
    rst_n = 1'b1;

`ifdef FETCH_RESET_VECTOR_EN
    cycle(1'b0, 1'b0, 32'd0);
    chk("vec_valid0", 32'(valid_out), 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    chk("vec_valid1", 32'(valid_out), 32'd0);
`endif

    // One-word instruction at 32
    cycle(1'b0, 1'b0, 32'd0);
    chk("s1_instr", 32'(instr_out), 32'h0000_A120);
    chk("s1_pc",    pc_out,         32'd32);

    // Two-word LDM at 33/34
    cycle(1'b0, 1'b0, 32'd0);
    chk("s2_wait_valid", 32'(valid_out), 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    chk("s2_instr", 32'(instr_out), 32'h0000_D020);
    chk("s2_imm",   32'(imm_out),   32'h0000_0005);
    chk("s2_pc",    pc_out,         32'd33);

    // Stall three cycles inside FETCH_IMM of the LDM at 35
    cycle(1'b0, 1'b0, 32'd0);
    repeat (3) cycle(1'b1, 1'b0, 32'd0);
    chk("s3_frozen_valid", 32'(valid_out), 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    chk("s3_imm", 32'(imm_out), 32'h0000_0007);
    chk("s3_pc",  pc_out,       32'd35);

    // Branch with stall while holding the LDM at 37
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'h40);
    chk("s4_valid", 32'(valid_out), 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    chk("s4_instr", 32'(instr_out), 32'h0000_2222);
    chk("s4_pc",    pc_out,         32'h40);

    // Wrap at the top of the address space
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 32'd0);
    chk("s5_pc", pc_out, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 32'd0);

    // Asynchronous reset in the middle of FETCH_IMM
    cycle(1'b0, 1'b1, 32'd37);
    cycle(1'b0, 1'b0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_in_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifdef FETCH_RESET_VECTOR_EN
    repeat (2) cycle(1'b0, 1'b0, 32'd0);
`endif
    cycle(1'b0, 1'b0, 32'd0);
    chk("s6_instr", 32'(instr_out), 32'h0000_A120);

    // Random program with random stalls and branches
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(0, 9) < 3) mem[i][15:14] = 2'b11;
      else if (mem[i][15:14] == 2'b11) mem[i][15] = 1'b0;
    end
    for (int n = 0; n < 400; n++) begin
      logic st;
      logic br;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      tgt = $urandom();
      cycle(st, br, tgt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
